frame_sequencer: RTL and testbench
==================================

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 The block SHALL have port reCLK, input, 1 bit: recovered bit clock; all state updates on its rising edge.
REQ-002 The block SHALL have port globalReset, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The block SHALL have port reData, input, 1 bit: serial frame data, sampled on reCLK rise.
REQ-004 The block SHALL have port REF16Bits, input, 16 bits: frame header pattern, quasi-static.
REQ-005 The block SHALL have port idleLen, input, 6 bits: consecutive-zero count that ends a frame; 0 means 64.
REQ-006 The block SHALL have port dataOut, output, 1 bit: serial stream to the next LED, driven from a register.
REQ-007 The block SHALL have ports Bdata, Gdata and Rdata, outputs, 12 bits each: latched colour words.
REQ-008 The block SHALL have port dataValid, output, 1 bit: one-cycle pulse on each colour-word update.
REQ-009 The block SHALL have port busy, output, 1 bit: high in every state except HUNT.
REQ-010 The block SHALL have port parityErr, output, 1 bit: one-cycle pulse on rejected payload; tied 0 when PAYLOAD_PARITY_EN is undefined.

Function
REQ-011 The block SHALL implement states HUNT, CAPTURE, FORWARD and DRAIN, with one 16-bit shift register sreg; dataOut = sreg[15].
REQ-012 In HUNT, the block SHALL shift reData into sreg[0] each edge, keep dataOut = 0 by masking, and compare {sreg[14:0],reData} against REF16Bits.
REQ-013 On a HUNT match, the block SHALL enter CAPTURE on that same edge, with a 6-bit bit counter cleared to 0.
REQ-014 CAPTURE SHALL sample P payload bits: P=36, or 37 with PAYLOAD_PARITY_EN.
REQ-015 Payload bit order SHALL be MSB-first: Bdata[11] first, then Gdata[11:0], then Rdata[11:0], then the parity bit when enabled; dataOut SHALL stay 0 throughout CAPTURE.
REQ-016 The shadow shift register SHALL be internal; Bdata, Gdata and Rdata SHALL change only on the edge that samples the last payload bit, with dataValid high for the following cycle only.
REQ-017 On the last payload edge, the block SHALL enter FORWARD and load sreg <= REF16Bits.
REQ-018 In FORWARD, the block SHALL shift sreg <= {sreg[14:0],reData} each edge, so the next LED sees the header MSB-first and then reData delayed by exactly 16 cycles.
REQ-019 In FORWARD, the block SHALL keep a zero-run counter: it increments on reData=0, clears on reData=1, and saturates at 63.
REQ-020 When the zero run reaches idleLen (64 when idleLen=0), the block SHALL enter DRAIN.
REQ-021 A header pattern arriving in FORWARD SHALL be forwarded as data and SHALL NOT restart capture.
REQ-022 DRAIN SHALL last exactly 16 cycles, shift in 0 while ignoring reData, then enter HUNT with sreg = 0.
REQ-023 A header arriving during DRAIN SHALL be lost; the sender must leave at least 16 idle bits plus idleLen between frames.

Reset
REQ-024 While globalReset = 0, the block SHALL hold state = HUNT, sreg = 0 and all counters at 0.
REQ-025 While globalReset = 0, the block SHALL hold Bdata = Gdata = Rdata = 0, and dataOut, dataValid, busy and parityErr at 0.
REQ-026 Reset asserted mid-CAPTURE or mid-FORWARD SHALL discard the partial payload and SHALL NOT pulse dataValid.
REQ-027 The first header SHALL be recognisable from the first reCLK edge after globalReset rises.

Configuration
REQ-028 With PAYLOAD_PARITY_EN defined, P=37; on the last edge the block SHALL latch the words and pulse dataValid only if the XOR of all 37 bits is 0.
REQ-029 With PAYLOAD_PARITY_EN defined and a parity failure, the block SHALL keep the old words and pulse parityErr; FORWARD is entered either way.
REQ-030 With PAYLOAD_PARITY_EN undefined, P=36, no parity logic SHALL exist, and parityErr SHALL be constant 0.

Verification
REQ-031 The bench SHALL cover: REF16Bits=16'hFFFE, header then B=12'hABC, G=12'h123, R=12'hFFF -> words latched on the 36th payload edge, dataValid high for 1 cycle, busy=1.
REQ-032 The bench SHALL cover: after REQ-031, 40 further bits 1010... -> dataOut emits 16'hFFFE MSB-first, then the 1010... pattern 16 cycles late.
REQ-033 The bench SHALL cover: idleLen=8, 8 zeros in FORWARD -> DRAIN for 16 cycles with dataOut=0 after the flushed bits, then busy=0.
REQ-034 The bench SHALL cover: globalReset pulled low at payload bit 20 -> all outputs 0 and no dataValid; a new frame after release is captured correctly.
REQ-035 The bench SHALL cover: 15 header bits then a mismatch -> stays in HUNT with dataOut=0; a valid header one bit later is detected.
REQ-036 The bench SHALL cover, with PAYLOAD_PARITY_EN defined: payload with odd XOR -> parityErr pulse, previous words held, FORWARD entered.

Source files
------------

// File: rtl/frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : frame_sequencer                                              |
// | Description : Daisy-chained LED frame sequencer. Hunts for a 16-bit        |
// |               header, captures a 36-bit B/G/R colour payload, regenerates  |
// |               the header and forwards the rest of the stream to the next   |
// |               LED with a 16-cycle delay, then drains after an idle run.    |
// |               Optional feature macro: PAYLOAD_PARITY_EN (adds a 37th       |
// |               even-parity payload bit and a parityErr pulse).              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module frame_sequencer (
    input  logic        reCLK,
    input  logic        globalReset,
    input  logic        reData,
    input  logic [15:0] REF16Bits,
    input  logic [5:0]  idleLen,
    output logic        dataOut,
    output logic [11:0] Bdata,
    output logic [11:0] Gdata,
    output logic [11:0] Rdata,
    output logic        dataValid,
    output logic        busy,
    output logic        parityErr
);

`ifdef PAYLOAD_PARITY_EN
    localparam int c_PLEN = 37;
`else
    localparam int c_PLEN = 36;
`endif
    localparam logic [5:0] c_LAST_BIT = 6'(c_PLEN - 1);
    localparam logic [3:0] c_DRAIN_LAST = 4'd15;
    localparam logic [5:0] c_ZRUN_MAX = 6'd63;

    localparam logic [1:0] c_HUNT    = 2'd0;
    localparam logic [1:0] c_CAPTURE = 2'd1;
    localparam logic [1:0] c_FORWARD = 2'd2;
    localparam logic [1:0] c_DRAIN   = 2'd3;

    logic [1:0]        r_state;
    logic [15:0]       r_sreg;
    logic [5:0]        r_bitcnt;
    logic [5:0]        r_zrun;
    logic [3:0]        r_draincnt;
    logic [c_PLEN-2:0] r_shadow;
    logic              r_dataOut;
    logic              r_dataValid;
    logic              r_busy;
    logic [11:0]       r_b;
    logic [11:0]       r_g;
    logic [11:0]       r_r;

    // Window seen by the header comparator / next value of the forward shifter
    logic [15:0]       w_window;
    logic              w_match;
    // Full payload including the bit being sampled on this edge
    logic [c_PLEN-1:0] w_payload;
    logic [35:0]       w_words;
    logic              w_last_bit;
    logic              w_accept;
    // Zero-run bookkeeping; 7 bits so an idleLen of 0 can mean a run of 64
    logic [6:0]        w_run_len;
    logic [6:0]        w_idle_target;
    logic              w_idle_hit;
    logic [5:0]        w_zrun_next;

    assign w_window      = {r_sreg[14:0], reData};
    assign w_match       = (w_window == REF16Bits);
    assign w_payload     = {r_shadow, reData};
    assign w_words       = w_payload[c_PLEN-1 -: 36];
    assign w_last_bit    = (r_bitcnt == c_LAST_BIT);
    assign w_run_len     = {1'b0, r_zrun} + 7'd1;
    assign w_idle_target = (idleLen == 6'd0) ? 7'd64 : {1'b0, idleLen};
    assign w_idle_hit    = !reData && (w_run_len == w_idle_target);
    assign w_zrun_next   = reData ? 6'd0 :
                           ((r_zrun == c_ZRUN_MAX) ? c_ZRUN_MAX : r_zrun + 6'd1);

`ifdef PAYLOAD_PARITY_EN
    logic r_parityErr;
    // Even parity over all payload bits, parity bit included
    assign w_accept  = ~^w_payload;
    assign parityErr = r_parityErr;
`else
    assign w_accept  = 1'b1;
    assign parityErr = 1'b0;
`endif

    // Sequencer: state, shifters, counters and all registered outputs
    always_ff @(posedge reCLK or negedge globalReset) begin
        if (!globalReset) begin
            r_state     <= c_HUNT;
            r_sreg      <= 16'd0;
            r_bitcnt    <= 6'd0;
            r_zrun      <= 6'd0;
            r_draincnt  <= 4'd0;
            r_shadow    <= '0;
            r_dataOut   <= 1'b0;
            r_dataValid <= 1'b0;
            r_busy      <= 1'b0;
            r_b         <= 12'd0;
            r_g         <= 12'd0;
            r_r         <= 12'd0;
`ifdef PAYLOAD_PARITY_EN
            r_parityErr <= 1'b0;
`endif
        end else begin
            // Pulses last exactly one cycle
            r_dataValid <= 1'b0;
`ifdef PAYLOAD_PARITY_EN
            r_parityErr <= 1'b0;
`endif
            case (r_state)
                c_HUNT: begin
                    // dataOut stays masked to 0 while hunting
                    r_sreg    <= w_window;
                    r_dataOut <= 1'b0;
                    if (w_match) begin
                        r_state  <= c_CAPTURE;
                        r_bitcnt <= 6'd0;
                        r_busy   <= 1'b1;
                    end
                end

                c_CAPTURE: begin
                    r_shadow  <= w_payload[c_PLEN-2:0];
                    r_bitcnt  <= r_bitcnt + 6'd1;
                    r_dataOut <= 1'b0;
                    if (w_last_bit) begin
                        // Regenerate the header for the next LED in the chain
                        r_state   <= c_FORWARD;
                        r_sreg    <= REF16Bits;
                        r_dataOut <= REF16Bits[15];
                        r_bitcnt  <= 6'd0;
                        r_zrun    <= 6'd0;
                        if (w_accept) begin
                            r_b         <= w_words[35:24];
                            r_g         <= w_words[23:12];
                            r_r         <= w_words[11:0];
                            r_dataValid <= 1'b1;
                        end
`ifdef PAYLOAD_PARITY_EN
                        else begin
                            r_parityErr <= 1'b1;
                        end
`endif
                    end
                end

                c_FORWARD: begin
                    // Headers seen here are plain data; only the idle run matters
                    r_sreg    <= w_window;
                    r_dataOut <= r_sreg[14];
                    r_zrun    <= w_zrun_next;
                    if (w_idle_hit) begin
                        r_state    <= c_DRAIN;
                        r_draincnt <= 4'd0;
                        r_zrun     <= 6'd0;
                    end
                end

                c_DRAIN: begin
                    // Flush the delay line with zeros; reData is ignored
                    r_draincnt <= r_draincnt + 4'd1;
                    if (r_draincnt == c_DRAIN_LAST) begin
                        r_state    <= c_HUNT;
                        r_sreg     <= 16'd0;
                        r_dataOut  <= 1'b0;
                        r_busy     <= 1'b0;
                        r_draincnt <= 4'd0;
                    end else begin
                        r_sreg    <= {r_sreg[14:0], 1'b0};
                        r_dataOut <= r_sreg[14];
                    end
                end

                default: begin
                    r_state <= c_HUNT;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dataOut   = r_dataOut;
    assign dataValid = r_dataValid;
    assign busy      = r_busy;
    assign Bdata     = r_b;
    assign Gdata     = r_g;
    assign Rdata     = r_r;

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_frame_sequencer                                           |
// | Description : Self-checking bench for frame_sequencer. Expected colour     |
// |               words and the expected dataOut stream are queued as          |
// |               stimulus is driven and compared as the DUT produces them.    |
// |               Honours PAYLOAD_PARITY_EN when defined.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_frame_sequencer;

`ifdef PAYLOAD_PARITY_EN
    localparam int c_PLEN = 37;
`else
    localparam int c_PLEN = 36;
`endif

    logic        clk = 1'b0;
    logic        globalReset;
    logic        reData;
    logic [15:0] REF16Bits;
    logic [5:0]  idleLen;
    logic        dataOut;
    logic [11:0] Bdata;
    logic [11:0] Gdata;
    logic [11:0] Rdata;
    logic        dataValid;
    logic        busy;
    logic        parityErr;

    int          n_checks = 0;
    int          n_errs   = 0;
    logic        exp_dv   = 1'b0;
    logic        exp_pe   = 1'b0;
    logic [35:0] last_w   = 36'd0;
    logic        dout_q[$];
    logic [35:0] word_q[$];

    frame_sequencer u_dut (
        .reCLK      (clk),
        .globalReset(globalReset),
        .reData     (reData),
        .REF16Bits  (REF16Bits),
        .idleLen    (idleLen),
        .dataOut    (dataOut),
        .Bdata      (Bdata),
        .Gdata      (Gdata),
        .Rdata      (Rdata),
        .dataValid  (dataValid),
        .busy       (busy),
        .parityErr  (parityErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One bit per clock; optionally queue the bit as future forwarded output
    task automatic tick(input logic b, input logic push);
        logic exp_do;
        reData = b;
        if (push) dout_q.push_back(b);
        @(posedge clk);
        #1;
        if (dout_q.size() > 0) exp_do = dout_q.pop_front();
        else                   exp_do = 1'b0;
        check("dataOut", dataOut, exp_do);
        check("dataValid", dataValid, exp_dv);
        check("parityErr", parityErr, exp_pe);
    endtask

    task automatic send_hdr(input logic [15:0] h);
        for (int i = 15; i >= 0; i--) begin
            tick(h[i], 1'b0);
            if (i == 1) check("busy_hunt", busy, 1'b0);
            if (i == 0) check("busy_capture", busy, 1'b1);
        end
    endtask

    // nbits < c_PLEN sends a truncated payload that must never be latched
    task automatic send_payload(input logic [11:0] b, input logic [11:0] g,
                                input logic [11:0] r, input int nbits, input logic bad);
        logic [36:0] bits;
        logic        good;
        logic [35:0] exp_w;
        good = 1'b1;
`ifdef PAYLOAD_PARITY_EN
        good = !bad;
`endif
        bits = {b, g, r, (^{b, g, r}) ^ bad};
        if (nbits == c_PLEN && good) word_q.push_back({b, g, r});
        for (int i = 0; i < nbits; i++) begin
            if (i == c_PLEN - 1) begin
                exp_dv = good;
`ifdef PAYLOAD_PARITY_EN
                exp_pe = !good;
`endif
                for (int k = 15; k >= 0; k--) dout_q.push_back(REF16Bits[k]);
            end
            tick(bits[36-i], 1'b0);
            exp_dv = 1'b0;
            exp_pe = 1'b0;
            if (i == c_PLEN - 1) begin
                if (good) begin
                    if (word_q.size() > 0) exp_w = word_q.pop_front();
                    else                   exp_w = last_w;
                    last_w = exp_w;
                end
                check("words", {Bdata, Gdata, Rdata}, last_w);
                check("busy_forward", busy, 1'b1);
            end
        end
    endtask

    task automatic fwd_alt(input int n);
        for (int i = 0; i < n; i++) tick((i % 2) == 0, 1'b1);
    endtask

    task automatic fwd_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) tick(w[i], 1'b1);
    endtask

    // A 1 to break any earlier zero run, then exactly idleLen zeros, then drain
    task automatic end_frame();
        int n;
        n = (idleLen == 6'd0) ? 64 : int'(idleLen);
        tick(1'b1, 1'b1);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b1);
        check("busy_drain_entry", busy, 1'b1);
        for (int d = 1; d <= 16; d++) begin
            tick(1'b1, 1'b0);
            if (d == 15) check("busy_drain15", busy, 1'b1);
            if (d == 16) check("busy_hunt_after_drain", busy, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        globalReset = 1'b0;
        reData      = 1'b0;
        REF16Bits   = 16'hFFFE;
        idleLen     = 6'd8;
        repeat (2) @(negedge clk);
        check("rst_dataOut", dataOut, 1'b0);
        check("rst_words", {Bdata, Gdata, Rdata}, 36'd0);
        check("rst_dataValid", dataValid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_parityErr", parityErr, 1'b0);
        globalReset = 1'b1;

        // Basic frame, then alternating data forwarded 16 cycles late, then idle drain
        send_hdr(16'hFFFE);
        send_payload(12'hABC, 12'h123, 12'hFFF, c_PLEN, 1'b0);
        fwd_alt(40);
        end_frame();

        // Reset in the middle of a payload discards it
        send_hdr(16'hFFFE);
        send_payload(12'h111, 12'h222, 12'h333, 20, 1'b0);
        globalReset = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_words", {Bdata, Gdata, Rdata}, 36'd0);
        check("midrst_dataValid", dataValid, 1'b0);
        check("midrst_dataOut", dataOut, 1'b0);
        last_w = 36'd0;
        dout_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("midrst_hold_busy", busy, 1'b0);
        check("midrst_hold_dataValid", dataValid, 1'b0);
        @(negedge clk);
        globalReset = 1'b1;
        send_hdr(16'hFFFE);
        send_payload(12'h5A5, 12'h0F0, 12'h00F, c_PLEN, 1'b0);
        // A header arriving during FORWARD is just data
        fwd_word(16'hFFFE);
        fwd_alt(5);
        check("fwd_hdr_busy", busy, 1'b1);
        end_frame();

        // Near-miss header: 15 matching bits then a wrong bit, then a good bit
        idleLen = 6'd3;
        for (int i = 0; i < 15; i++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        check("miss_busy", busy, 1'b0);
        tick(1'b0, 1'b0);
        check("late_hdr_busy", busy, 1'b1);
        send_payload(12'h800, 12'h001, 12'h7FE, c_PLEN, 1'b0);
        fwd_alt(7);
        end_frame();

`ifdef PAYLOAD_PARITY_EN
        // Bad parity: old words held, parityErr pulses, forwarding still happens
        idleLen = 6'd4;
        send_hdr(16'hFFFE);
        send_payload(12'h246, 12'h8AC, 12'hE01, c_PLEN, 1'b1);
        fwd_alt(20);
        end_frame();
`endif

        check("final_busy", busy, 1'b0);
        check("words_queue_empty", 36'(word_q.size()), 36'd0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
